// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the capture FIFO write port among NREQ producers.
// Bursts are capped at MAX_BURST beats; a shadow occupancy count back-pressures before overflow.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 4,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               fifo_wvalid,
    output logic [DW-1:0]      fifo_wdata,
    input  logic               fifo_rd,
    input  logic               fifo_empty,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic [2:0]         grant_id
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    logic [2:0]          rr_ptr;
    logic [3:0]          beat_cnt;
    logic [2*NREQ-1:0]   valid_dbl;
    logic [NREQ-1:0]     valid_rot;
    logic                found;
    logic [2:0]          offset;
    logic [3:0]          offset_sum;
    logic [2:0]          winner;
    logic [2:0]          sel_id;
    logic                grant_ok;
    logic                owner_valid;
    logic [DW-1:0]       sel_data;
    logic                accept;
    logic                rd_q;

    function automatic logic [2:0] next_ptr(input logic [2:0] p);
        return (p == 3'(NREQ - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // Rotating the valid vector by rr_ptr turns round-robin into a plain lowest-index search.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = NREQ'(valid_dbl >> rr_ptr);

    always_comb begin
        found      = 1'b0;
        offset     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                found  = 1'b1;
                offset = 3'(k);
            end
        end
        offset_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (offset_sum >= 4'(NREQ)) begin
            offset_sum = offset_sum - 4'(NREQ);
        end
        winner = offset_sum[2:0];
    end

    always_comb begin
        sel_id      = grant_id;
        grant_ok    = 1'b1;
        if (state == IDLE) begin
            sel_id   = winner;
            grant_ok = found;
        end
        grant_ok    = grant_ok & ~full & reset;
        req_ready   = '0;
        sel_data    = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == sel_id) begin
                req_ready[i] = grant_ok;
                sel_data     = req_data[i*DW +: DW];
            end
            if (3'(i) == grant_id) begin
                owner_valid = req_valid[i];
            end
        end
    end

    assign accept = |(req_valid & req_ready);
    assign rd_q   = fifo_rd & ~fifo_empty;
    assign full   = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id <= winner;
                        beat_cnt <= 4'd1;
                        if (MAX_BURST > 1) begin
                            state <= BURST;
                        end else begin
                            rr_ptr <= next_ptr(winner);
                        end
                    end
                end
                BURST: begin
                    // Owner dropping valid ends the burst; a full stall simply holds.
                    if (!owner_valid) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr(grant_id);
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt + 4'd1 == 4'(MAX_BURST)) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr(grant_id);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_wvalid <= 1'b0;
            fifo_wdata  <= '0;
        end else begin
            fifo_wvalid <= accept;
            if (accept) begin
                fifo_wdata <= sel_data;
            end
        end
    end

    // The slot is reserved at accept time, so the in-flight write is already counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (accept && !rd_q && !full) begin
            count <= count + CW'(1);
        end else if (rd_q && !accept && count != '0) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter and occupancy controller for the 256-deep SoC capture FIFO.
- Shares the FIFO's single write port (valid strobe plus 32-bit data) between NREQ producers using per-requester valid/ready handshakes.
- Bounds grants to MAX_BURST beats so no producer can hog the port.
- The FIFO has no full flag, so this block keeps a shadow occupancy count from writes and qualified reads, and back-pressures producers before overflow.

Parameters:
NREQ, 4, number of requesting producers (2..8)
DW, 32, data width per beat
DEPTH, 256, FIFO capacity in words
MAX_BURST, 4, max consecutive beats granted to one requester (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*DW  packed beat data, requester i at bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept, combinational, at most one bit high
fifo_wvalid  output  1  registered write strobe to FIFO
fifo_wdata  output  DW  registered write data to FIFO
fifo_rd  input  1  FIFO read enable (consumer side)
fifo_empty  input  1  FIFO empty flag
count  output  9  shadow occupancy including the in-flight write, 0..DEPTH
full  output  1  count == DEPTH
grant_id  output  3  index of the current/last granted requester

Behaviour:
- Reset (reset low, async) values:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0.
  - count = 0, fifo_wvalid = 0, fifo_wdata = 0, grant_id = 0.
  - req_ready = 0, full = 0.
- Accept: a beat is accepted when req_valid[i] & req_ready[i] in the same cycle.
- Write latency: an accepted beat appears on fifo_wvalid/fifo_wdata on the next cycle. fifo_wvalid is high exactly one cycle per accepted beat, otherwise 0. fifo_wdata holds its value when there is no accept.
- Qualified read: rd_q = fifo_rd & ~fifo_empty.
- Count update (saturating):
  - count += 1 on accept, and -= 1 on rd_q.
  - Accept and rd_q in the same cycle: count unchanged.
  - The slot is reserved at accept time, so the in-flight write is counted.
- full is combinational from count. While full, req_ready is all zeros.
- A read in a cycle when full=1 frees one slot; ready may assert on the following cycle only.
- State IDLE:
  - Winner = first i with req_valid[i] high, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - If a winner exists and ~full: req_ready[winner] = 1, the beat is accepted, grant_id <= winner, beat_cnt <= 1.
  - If MAX_BURST > 1, go to BURST (owner = winner). Otherwise set rr_ptr <= winner+1 mod NREQ and stay in IDLE.
  - If no winner, or full: no ready, stay in IDLE.
- State BURST (owner = grant_id):
  - req_ready[owner] = ~full. All other ready bits are 0.
  - On accept: beat_cnt += 1. If the new beat_cnt == MAX_BURST, go to IDLE and set rr_ptr <= owner+1.
  - If req_valid[owner] is low: no accept; go to IDLE and set rr_ptr <= owner+1.
  - If full while owner is valid: hold BURST, no accept, beat_cnt unchanged.
- Fairness: after a burst ends, the owner has lowest priority. With all NREQ valid, grants rotate 0,1,2,3,0,... in MAX_BURST-beat bursts.
- Data is never dropped or duplicated. Each accepted beat produces exactly one fifo_wvalid pulse.
- Reset mid-burst: all state is cleared immediately. Any in-flight fifo_wvalid is cancelled and count returns to 0. The FIFO is reset by the same reset, so this is consistent.
- grant_id, rr_ptr and beat_cnt are registered. Arbitration logic is combinational from registered state and req_valid only. fifo_rd does not feed req_ready combinationally.

Test Plan:
1. Reset, then req_valid = 4'b0001 for 3 cycles with data 0xA0, 0xA1, 0xA2 -> req_ready[0] high 3 cycles. fifo_wvalid pulses one cycle later with 0xA0, 0xA1, 0xA2. count = 3, grant_id = 0.
2. All four requesters continuously valid, MAX_BURST = 4, no reads -> beats 1-4 from req0, 5-8 from req1, 9-12 from req2, 13-16 from req3, then req0 again. count = 16 after 16 accepts.
3. Fill to count = 256 with fifo_rd = 0 -> full = 1, req_ready = 0 while the owner stays valid. Pulse fifo_rd once with fifo_empty = 0 -> count = 255, one more beat accepted on the following cycle, count = 256.
4. Simultaneous accept and qualified read at count = 10 -> count stays 10. fifo_rd = 1 with fifo_empty = 1 -> count unchanged.
5. Owner (req2) drops valid after 2 beats while req1 and req3 are valid -> state returns to IDLE with rr_ptr = 3. The next grant goes to req3, then req1.
6. Assert reset in the middle of a burst with count = 5 -> count = 0, fifo_wvalid = 0, req_ready = 0 immediately. After release, the first grant goes to the lowest-index valid requester starting from 0.
